// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction fields, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  // ALU opcodes; NOP keeps the ALU idle between issues.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  // Instruction layout: {op, rd, rs1, rs2_or_imm}; rs2 is the top 3 bits of the imm field.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } issue_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL});
  endfunction

  // Immediate forms take src2 from the instruction instead of the register file.
  function automatic logic op_is_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/cpu_regfile_8x16.sv
// 8x16 register file: two operand read ports, one debug read port, one write port; r0 reads zero.
// Latency: reads combinational; write visible on reads in the cycle after the write edge.
// Backpressure: none; a write is taken on every cycle i_we is high (writes to r0 dropped).
module cpu_regfile_8x16
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_ra_addr,
  input  logic [2:0]  i_rb_addr,
  input  logic [2:0]  i_dbg_addr,
  output logic [15:0] o_ra_data,
  output logic [15:0] o_rb_data,
  output logic [15:0] o_dbg_data,
  input  logic        i_we,
  input  logic [2:0]  i_wa,
  input  logic [15:0] i_wd
);

  logic [15:0] r_rf [8];

  // Clear on reset; accept writes except to the hardwired-zero r0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= '0;
      end
    end else if (i_we && (i_wa != 3'd0)) begin
      r_rf[i_wa] <= i_wd;
    end
  end

  // Asynchronous reads, with r0 forced to zero regardless of storage.
  always_comb begin
    o_ra_data  = (i_ra_addr  == 3'd0) ? 16'h0000 : r_rf[i_ra_addr];
    o_rb_data  = (i_rb_addr  == 3'd0) ? 16'h0000 : r_rf[i_rb_addr];
    o_dbg_data = (i_dbg_addr == 3'd0) ? 16'h0000 : r_rf[i_dbg_addr];
  end

endmodule

// File: rtl/cpu_ula_issue.sv
// Issues one ALU instruction at a time: latch operands, drive the ALU, wait for done, write back.
// Latency: handshake at N, ALU op at N+1, write-back pulse at N+4, ready again at N+5.
// Backpressure: instr_ready high only in IDLE; instr_valid while busy is ignored until then.
module cpu_ula_issue
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 8
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_instr_valid,
  input  logic [15:0] i_instr,
  output logic        o_instr_ready,
  output logic [2:0]  o_alu_op_code,
  output logic [15:0] o_alu_src1,
  output logic [15:0] o_alu_src2,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_done,
  output logic        o_wb_valid,
  output logic [2:0]  o_wb_addr,
  output logic [15:0] o_wb_data,
  output logic        o_err_illegal,
  output logic        o_err_timeout,
  output logic        o_busy,
  input  logic [2:0]  i_dbg_addr,
  output logic [15:0] o_dbg_data
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  issue_state_t r_state;
  issue_state_t w_state_nxt;

  logic [2:0]       r_op;
  logic [2:0]       r_rd;
  logic [15:0]      r_src1;
  logic [15:0]      r_src2;
  logic [15:0]      r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_illegal;
  logic             r_err_timeout;

  logic [2:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [6:0]  w_imm;
  logic [15:0] w_rs1_data;
  logic [15:0] w_rs2_data;
  logic        w_legal;
  logic        w_idle_vld;
  logic        w_cnt_clr;
  logic        w_capture;
  logic        w_timeout;

  assign w_op       = i_instr[OP_MSB:OP_LSB];
  assign w_rd       = i_instr[RD_MSB:RD_LSB];
  assign w_rs1      = i_instr[RS1_MSB:RS1_LSB];
  assign w_rs2      = i_instr[RS2_MSB:RS2_LSB];
  assign w_imm      = i_instr[IMM_MSB:IMM_LSB];
  assign w_legal    = op_legal(w_op);
  assign w_idle_vld = (r_state == ST_IDLE) && i_instr_valid;

  cpu_regfile_8x16 u_rf (
    .clk        (clk),
    .reset      (reset),
    .i_ra_addr  (w_rs1),
    .i_rb_addr  (w_rs2),
    .i_dbg_addr (i_dbg_addr),
    .o_ra_data  (w_rs1_data),
    .o_rb_data  (w_rs2_data),
    .o_dbg_data (o_dbg_data),
    .i_we       (o_wb_valid),
    .i_wa       (r_rd),
    .i_wd       (r_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control; the ALU only sees a real opcode during ISSUE.
  always_comb begin
    w_state_nxt   = r_state;
    o_instr_ready = 1'b0;
    o_busy        = 1'b1;
    o_alu_op_code = OP_NOP;
    o_wb_valid    = 1'b0;
    w_cnt_clr     = 1'b0;
    w_capture     = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_instr_ready = 1'b1;
        o_busy        = 1'b0;
        if (i_instr_valid && w_legal) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_alu_op_code = r_op;
        w_cnt_clr     = 1'b1;
        w_state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_alu_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_WRITE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        o_wb_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand latch at accept, wait counter, result capture, error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op          <= OP_NOP;
      r_rd          <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_res         <= '0;
      r_cnt         <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_illegal <= w_idle_vld && !w_legal;
      r_err_timeout <= w_timeout;
      if (w_idle_vld && w_legal) begin
        r_op   <= w_op;
        r_rd   <= w_rd;
        r_src1 <= w_rs1_data;
        r_src2 <= op_is_imm(w_op) ? {9'b0, w_imm} : w_rs2_data;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT) && !i_alu_done && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_res <= i_alu_result;
      end
    end
  end

  assign o_alu_src1    = r_src1;
  assign o_alu_src2    = r_src2;
  assign o_wb_addr     = r_rd;
  assign o_wb_data     = r_res;
  assign o_err_illegal = r_err_illegal;
  assign o_err_timeout = r_err_timeout;

endmodule
